serial_operand_loader: RTL and testbench
========================================

# serial_operand_loader

Upstream feeder for the bit-serial adder. Accepts a pair of W-bit operands through a valid/ready handshake and presents them LSB-first, one bit pair per clock, on the adder's x/y inputs. It marks the first and last bit of each word so the adder's carry state can be cleared at word boundaries, supports a stall input, and accepts back-to-back words with no idle cycle.

## Interface
- W, default 8: operand width in bits; W >= 1.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair a/b is presented.
- in_ready  output  1  loader will capture a/b at this edge if in_valid.
- a  input  W  operand A, parallel.
- b  input  W  operand B, parallel.
- hold  input  1  stall; freezes the shift registers and the bit counter.
- x  output  1  current bit of A, feeds adder x.
- y  output  1  current bit of B, feeds adder y.
- bit_valid  output  1  x/y carry a live bit.
- first  output  1  current bit is bit 0; the downstream adder treats carry-in as 0.
- last  output  1  current bit is bit W-1.

## Operation
- States: IDLE, SHIFT.
- Registers: sh_a[W], sh_b[W], cnt (width clog2(max(W,2))), state.
- Outputs are decoded from registers only, with no input-to-output path except in_ready:
  - x = sh_a[0], y = sh_b[0]
  - bit_valid = (state==SHIFT)
  - first = bit_valid & (cnt==0)
  - last = bit_valid & (cnt==W-1)
- in_ready = (state==IDLE) | (last & ~hold). This is combinational.
- Load happens when in_valid & in_ready: sh_a<=a, sh_b<=b, cnt<=0, state<=SHIFT. Load is independent of hold while in IDLE.
- Shift happens in SHIFT, when hold=0 and last=0: sh_a/sh_b shift right with 0 fill, and cnt<=cnt+1.
- On last with hold=0:
  - if in_valid, load the next pair and stay in SHIFT (back-to-back);
  - otherwise go to IDLE and clear cnt and the shift registers.
- hold=1 in SHIFT: all registers unchanged; x, y, first and last stay stable.
- W=1: first and last are both high on the single bit.
- The carry contract: the adder must use carry-in 0 whenever first=1. No separate clear pulse is produced.

## Timing
- Reset (reset_n low, asynchronous):
  - state=IDLE, sh_a=sh_b=0, cnt=0
  - x=y=bit_valid=first=last=0
  - in_ready=1, both during reset and in the first cycle after it.
- Reset asserted mid-word: the word is abandoned at once, all outputs return to their reset values asynchronously, and nothing resumes after release.
- Latency: pair accepted at edge N → bit 0 is visible after edge N → bit k is visible after edge N+k (no hold) → last is high in cycle N+W-1.
- Throughput: one word per W cycles with continuous in_valid and hold=0. bit_valid never drops between back-to-back words.
- Each cycle with hold=1 extends the word by one cycle. Bit order and values do not change.
- in_valid while in SHIFT and not on an unheld last bit: not accepted (in_ready=0). The source holds a/b until in_ready=1.
- hold=1 on the last bit: in_ready=0 and no load. The load occurs on the first cycle hold drops.

## Structure
- Shared package serial_pkg:
  - state enum {IDLE, SHIFT}
  - default width constant SERIAL_W=8
  - the same package is reused by the adder and the downstream sum collector.
- Optional sub-module serial_bit_counter:
  - parameter W; inputs clr, en;
  - outputs cnt, is_first, is_last.
  - The same counter is natural for the downstream collector.
- The shift registers stay inline. Target size is 120–200 lines of RTL.

## Test plan
- Reset then single word: W=8, a=8'hB5, b=8'h3C, hold=0 → x sequence 1,0,1,0,1,1,0,1 and y sequence 0,0,1,1,1,1,0,0. first high in cycle 0, last high in cycle 7, then IDLE with in_ready=1.
- Back-to-back: two pairs (8'hFF,8'h01) then (8'h0F,8'hF0), with in_valid held → 16 continuous bit_valid cycles. first is high on cycles 0 and 8, last on cycles 7 and 15. in_ready is high only in cycles 7 and 15 after the first accept.
- Stall: hold=1 for 3 cycles at bit 4 of a=8'hA5 → x stays 0 for 4 cycles, then bits resume 1,0,1. Total word length is 11 cycles.
- Hold on last: hold=1 on bit 7 with in_valid pending → in_ready=0 while hold is high. The next word loads on the edge after hold drops.
- Async reset mid-word: drop reset_n between edges at bit 3 → all outputs are 0 immediately and in_ready=1. After release there is no bit_valid until a new handshake.
- W=1 instance: a=1, b=1 → one cycle with x=y=1 and first=last=1. Back-to-back accept works every cycle.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial datapath (loader, adder, sum collector).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_pkg;

  // Word sequencing state shared by the serial blocks.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Default operand width.
  localparam int SERIAL_W = 8;

  // Bit-index counter width; at least one bit so W=1 still has a real register.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Bit-position counter for a W-bit serial word, flags first and last bit.
// Latency: clr/en take effect on the next rising edge; flags decode from the register.
// Backpressure: none; the caller freezes it by holding en low.
module serial_bit_counter
  import serial_pkg::*;
#(
  parameter int W = SERIAL_W,
  localparam int CW = cnt_w(W)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          is_first,
  output logic          is_last
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over increment so a reload restarts at bit 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign is_first = (cnt_q == '0);
  assign is_last  = (cnt_q == CW'(W - 1));

endmodule

// File: rtl/serial_operand_loader.sv
// Loads an operand pair and streams it LSB-first, one bit pair per clock, with first/last marks.
// Latency: pair accepted at edge N shows bit k after edge N+k; back-to-back words with no gap.
// Backpressure: in_ready only in IDLE or on an unheld last bit; hold freezes the word in place.
module serial_operand_loader
  import serial_pkg::*;
#(
  parameter int W = SERIAL_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         hold,
  output logic         x,
  output logic         y,
  output logic         bit_valid,
  output logic         first,
  output logic         last
);

  localparam int CW = cnt_w(W);

  state_t        state_q, state_d;
  logic [W-1:0]  sh_a_q, sh_a_d;
  logic [W-1:0]  sh_b_q, sh_b_d;
  logic          cnt_clr;
  logic          cnt_en;
  logic [CW-1:0] cnt;
  logic          is_first;
  logic          is_last;
  logic          load;

  serial_bit_counter #(.W(W)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .cnt      (cnt),
    .is_first (is_first),
    .is_last  (is_last)
  );

  // Outputs come from registers only; in_ready is the one combinational path from hold.
  assign x         = sh_a_q[0];
  assign y         = sh_b_q[0];
  assign bit_valid = (state_q == SHIFT);
  assign first     = bit_valid & is_first;
  assign last      = bit_valid & is_last;
  assign in_ready  = (state_q == IDLE) | (last & ~hold);
  assign load      = in_valid & in_ready;

  // Next state: load (also back-to-back on last), shift, or retire the word to IDLE.
  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (load) begin
      state_d = SHIFT;
      sh_a_d  = a;
      sh_b_d  = b;
      cnt_clr = 1'b1;
    end else if (state_q == SHIFT && !hold) begin
      if (last) begin
        state_d = IDLE;
        sh_a_d  = '0;
        sh_b_d  = '0;
        cnt_clr = 1'b1;
      end else begin
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        cnt_en  = 1'b1;
      end
    end
  end

  // State and shift registers; reset abandons any word in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
    end
  end

  // The bit index must never run past the word while shifting.
  cnt_in_range: assert property (@(posedge clk) disable iff (!reset_n)
    bit_valid |-> (cnt <= CW'(W - 1)));

endmodule

// File: tb/tb_serial_operand_loader.sv
module tb_serial_operand_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, hold;
  logic [7:0] a, b;
  logic       in_ready, x, y, bit_valid, first, last;

  logic       in_valid1, hold1;
  logic [0:0] a1, b1;
  logic       in_ready1, x1, y1, bit_valid1, first1, last1;

  int checks = 0;
  int errors = 0;

  // expected {x, y, first, last} per bit, in order
  logic [3:0] q8[$];
  logic [3:0] q1[$];

  always #5 clk = ~clk;

  serial_operand_loader #(.W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .hold(hold), .x(x), .y(y), .bit_valid(bit_valid),
    .first(first), .last(last)
  );

  serial_operand_loader #(.W(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .hold(hold1), .x(x1), .y(y1), .bit_valid(bit_valid1),
    .first(first1), .last(last1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a pair until accepted; expected bits are queued at the accepting edge.
  task automatic send8(input logic [7:0] av, input logic [7:0] bv, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    while (!done && waits < 50) begin
      @(negedge clk);
      if (in_ready) begin
        for (int k = 0; k < 8; k++) q8.push_back({av[k], bv[k], k == 0, k == 7});
        done = 1'b1;
      end else begin
        waits++;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send8_timeout: got no in_ready expected accept within 50 cycles");
    end
  endtask

  task automatic send1(input logic av, input logic bv, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    in_valid1 = 1'b1;
    a1 = av;
    b1 = bv;
    while (!done && waits < 50) begin
      @(negedge clk);
      if (in_ready1) begin
        q1.push_back({av, bv, 1'b1, 1'b1});
        done = 1'b1;
      end else begin
        waits++;
      end
      tick();
    end
    in_valid1 = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send1_timeout: got no in_ready expected accept within 50 cycles");
    end
  endtask

  // Monitor for the W=8 instance: compare every live bit against the queue head.
  always @(negedge clk) begin
    if (reset_n && bit_valid) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bit8_unexpected: got bit_valid=1 x=%0b y=%0b expected no live bit", x, y);
      end else begin
        chk("bit8_xyfl", {x, y, first, last}, q8[0]);
        if (!hold) void'(q8.pop_front());
      end
    end
  end

  // Monitor for the W=1 instance.
  always @(negedge clk) begin
    if (reset_n && bit_valid1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bit1_unexpected: got bit_valid=1 x=%0b y=%0b expected no live bit", x1, y1);
      end else begin
        chk("bit1_xyfl", {x1, y1, first1, last1}, q1[0]);
        if (!hold1) void'(q1.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1);
  end

  initial begin
    int w;
    int cnt;
    reset_n = 1'b0;
    in_valid = 1'b0;
    hold = 1'b0;
    a = '0;
    b = '0;
    in_valid1 = 1'b0;
    hold1 = 1'b0;
    a1 = '0;
    b1 = '0;

    // Reset values, during reset and in the first cycle after release
    #3;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_outs", {x, y, bit_valid, first, last}, 5'b0);
    #9;
    chk("rst_outs_after_edge", {x, y, bit_valid, first, last}, 5'b0);
    chk("rst_in_ready1", in_ready1, 1'b1);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_bit_valid", bit_valid, 1'b0);
    tick();

    // Single word B5/3C
    send8(8'hB5, 8'h3C, w);
    chk("single_wait", w, 0);
    repeat (8) tick();
    @(negedge clk);
    chk("single_idle_bv", bit_valid, 1'b0);
    chk("single_idle_rdy", in_ready, 1'b1);
    tick();

    // Back-to-back: second pair waits through cycles 0..6, accepted in cycle 7
    send8(8'hFF, 8'h01, w);
    send8(8'h0F, 8'hF0, w);
    chk("b2b_wait", w, 7);
    cnt = 0;
    for (int i = 8; i < 16; i++) begin
      @(negedge clk);
      if (bit_valid) cnt++;
      if (i == 15) chk("b2b_rdy_c15", in_ready, 1'b1);
      else chk("b2b_rdy_low", in_ready, 1'b0);
      tick();
    end
    chk("b2b_second_word_bv", cnt, 8);
    @(negedge clk);
    chk("b2b_idle", bit_valid, 1'b0);
    tick();

    // Stall for 3 cycles at bit 4 of A5
    send8(8'hA5, 8'h5A, w);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      hold = (i >= 4 && i <= 6);
      @(negedge clk);
      if (!bit_valid) break;
      cnt++;
      if (hold) chk("stall_rdy", in_ready, 1'b0);
      tick();
    end
    hold = 1'b0;
    chk("stall_len", cnt, 11);
    tick();

    // Hold on the last bit with the next pair pending
    send8(8'hC3, 8'h5A, w);
    repeat (7) tick();
    hold = 1'b1;
    in_valid = 1'b1;
    a = 8'h81;
    b = 8'h7E;
    @(negedge clk);
    chk("hold_last_flag", last, 1'b1);
    chk("hold_last_rdy0", in_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("hold_last_rdy1", in_ready, 1'b0);
    tick();
    hold = 1'b0;
    send8(8'h81, 8'h7E, w);
    chk("hold_last_load_wait", w, 0);
    repeat (8) tick();
    @(negedge clk);
    chk("hold_last_idle", bit_valid, 1'b0);
    tick();

    // Async reset mid-word at bit 3
    send8(8'h66, 8'h99, w);
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_outs", {x, y, bit_valid, first, last}, 5'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    q8.delete();
    @(posedge clk);
    #3 reset_n = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bit_valid) cnt++;
    end
    chk("arst_no_resume", cnt, 0);
    chk("arst_rdy_after", in_ready, 1'b1);
    tick();

    // W=1 instance, back-to-back every cycle
    send1(1'b1, 1'b1, w);
    chk("w1_first_wait", w, 0);
    send1(1'b0, 1'b1, w);
    chk("w1_b2b_wait_a", w, 0);
    send1(1'b1, 1'b0, w);
    chk("w1_b2b_wait_b", w, 0);
    tick();
    @(negedge clk);
    chk("w1_idle", bit_valid1, 1'b0);
    tick();

    chk("q8_drained", q8.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
